// File: rtl/seq_shift_add_mult_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
// START is a request, taken only while BUSY=0; READY qualifies P and stays high until the next taken START.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 4
);
  logic                 START;
  logic                 SIGNED;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   P;
  logic                 READY;
  logic                 BUSY;

  modport master (
    output START,
    output SIGNED,
    output A,
    output B,
    input  P,
    input  READY,
    input  BUSY
  );

  modport slave (
    input  START,
    input  SIGNED,
    input  A,
    input  B,
    output P,
    output READY,
    output BUSY
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one partial product per clock on operand magnitudes,
// with the sign applied to the finished product in a single FIX cycle.
module seq_shift_add_mult #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  CK,
  input  logic                  RST_N,
  seq_shift_add_mult_if.slave   bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     ax_q, ax_d;
  logic [WIDTH-1:0]     mr_q, mr_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic                 accept;
  logic                 cnt_last;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;

  assign accept   = bus.START & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (cnt_last) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (accept) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.P     = p_q;
    bus.READY = (state_q == S_DONE);
    bus.BUSY  = (state_q == S_RUN) | (state_q == S_FIX);
    state_dbg = state_q;
  end

  // Operand magnitudes; the most negative value maps onto its unsigned magnitude.
  always_comb begin
    a_mag = bus.A;
    b_mag = bus.B;
    if (bus.SIGNED & bus.A[WIDTH-1]) a_mag = ~bus.A + 1'b1;
    if (bus.SIGNED & bus.B[WIDTH-1]) b_mag = ~bus.B + 1'b1;
  end

  always_comb begin
    sum  = acc_q + {1'b0, (mr_q[0] ? ax_q : {WIDTH{1'b0}})};
    prod = {acc_q[WIDTH-1:0], mr_q};
  end

  // Datapath next-state
  always_comb begin
    ax_d  = ax_q;
    mr_d  = mr_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    p_d   = p_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          ax_d  = a_mag;
          mr_d  = b_mag;
          acc_d = '0;
          cnt_d = '0;
          neg_d = bus.SIGNED & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        end
      end
      S_RUN: begin
        // {ACC,MR} shifts right as one 2*WIDTH+1 bit register.
        acc_d = {1'b0, sum[WIDTH:1]};
        mr_d  = {sum[0], mr_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
      end
      S_FIX: begin
        p_d = neg_q ? (~prod + 1'b1) : prod;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      ax_q  <= '0;
      mr_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      p_q   <= '0;
    end else begin
      ax_q  <= ax_d;
      mr_q  <= mr_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      p_q   <= p_d;
    end
  end

endmodule
